// File: rtl/ps2_codes_pkg.sv
// Scan-code constants, decoder state encoding and small byte-classification
// helpers shared by the PS/2 key decoder and its timer.
package ps2_codes_pkg;

  // Tracked key codes (set 2, non-extended)
  localparam logic [7:0] KEY_1      = 8'h16;
  localparam logic [7:0] KEY_2      = 8'h1E;
  localparam logic [7:0] KEY_SPACE  = 8'h29;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;
  localparam logic [7:0] KEY_ESC    = 8'h76;

  // Prefix bytes
  localparam logic [7:0] PFX_E0     = 8'hE0;
  localparam logic [7:0] PFX_F0     = 8'hF0;
  localparam logic [7:0] PFX_E1     = 8'hE1;

  // Keyboard status / error bytes
  localparam logic [7:0] BAT_AA     = 8'hAA;
  localparam logic [7:0] ACK_FA     = 8'hFA;
  localparam logic [7:0] ECHO_EE    = 8'hEE;
  localparam logic [7:0] RESEND_FE  = 8'hFE;
  localparam logic [7:0] ERR_00     = 8'h00;
  localparam logic [7:0] ERR_FF     = 8'hFF;

  // Level vector bit positions
  localparam int LVL_ONE   = 0;
  localparam int LVL_TWO   = 1;
  localparam int LVL_SPACE = 2;
  localparam int LVL_ENTER = 3;
  localparam int LVL_ESC   = 4;
  localparam int NUM_KEYS  = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GOT_E0   = 3'd1,
    ST_GOT_F0   = 3'd2,
    ST_GOT_E0F0 = 3'd3,
    ST_SKIP     = 3'd4
  } dec_state_t;

  // One-hot level mask for a tracked key code, zero for any other code.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code);
    logic [NUM_KEYS-1:0] mask;
    case (code)
      KEY_1:     mask = 5'b00001;
      KEY_2:     mask = 5'b00010;
      KEY_SPACE: mask = 5'b00100;
      KEY_ENTER: mask = 5'b01000;
      KEY_ESC:   mask = 5'b10000;
      default:   mask = 5'b00000;
    endcase
    return mask;
  endfunction

  // True for any of the three prefix bytes.
  function automatic logic is_prefix(input logic [7:0] code);
    return (code == PFX_E0) || (code == PFX_F0) || (code == PFX_E1);
  endfunction

  // True for keyboard status bytes that carry no key information.
  function automatic logic is_status(input logic [7:0] code);
    return (code == BAT_AA) || (code == ACK_FA) ||
           (code == ECHO_EE) || (code == RESEND_FE);
  endfunction

  // True for the receive-overrun / error bytes.
  function automatic logic is_overrun(input logic [7:0] code);
    return (code == ERR_00) || (code == ERR_FF);
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle-cycle counter used to abandon a half-received prefix sequence.
// timeout is asserted on the enabled cycle where the count reaches
// TIMEOUT_CYCLES-1; clear has priority over enable.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count idle cycles while enabled, saturating at the terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign timeout = enable && !clear && (count == LAST);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: turns the received byte stream into held-key
// levels for 1, 2, Space, Enter and Esc plus a one-cycle key-event strobe
// carrying the code, make/break and extended flags of the last event.
module ps2_key_decoder
  import ps2_codes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic [7:0] iByte,
  input  logic       iByteValid,
  output logic       oOnePressed,
  output logic       oTwoPressed,
  output logic       oSpacePressed,
  output logic       oEnterPressed,
  output logic       oEscPressed,
  output logic       oKeyEvent,
  output logic [7:0] oKeyCode,
  output logic       oMake,
  output logic       oExtended
);

  localparam int SKIP_W = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP + 1) : 1;

  dec_state_t          state;
  dec_state_t          state_next;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [SKIP_W-1:0]   skip_next;
  logic                timeout;

  logic                evt_fire;
  logic                evt_make;
  logic                evt_ext;
  logic [NUM_KEYS-1:0] lvl_set;
  logic [NUM_KEYS-1:0] lvl_clr;

  logic [NUM_KEYS-1:0] levels;
  logic                key_event;
  logic [7:0]          key_code;
  logic                key_make;
  logic                key_ext;

  // The prefix timer only runs while a sequence is in progress and no byte
  // arrives; any byte or a return to IDLE restarts it.
  ps2_prefix_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (iReset),
    .clear  (iByteValid || (state == ST_IDLE)),
    .enable (state != ST_IDLE),
    .timeout(timeout)
  );

  // State and Pause-skip counter registers.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // Next-state decode from the current state and the incoming byte.
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    if (timeout) begin
      state_next = ST_IDLE;
      skip_next  = '0;
    end else if (iByteValid) begin
      case (state)
        ST_IDLE: begin
          if (iByte == PFX_E0) begin
            state_next = ST_GOT_E0;
          end else if (iByte == PFX_F0) begin
            state_next = ST_GOT_F0;
          end else if ((iByte == PFX_E1) && (PAUSE_SKIP > 0)) begin
            state_next = ST_SKIP;
            skip_next  = SKIP_W'(PAUSE_SKIP);
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_GOT_E0: begin
          if (iByte == PFX_F0) begin
            state_next = ST_GOT_E0F0;
          end else if (iByte == PFX_E0) begin
            state_next = ST_GOT_E0;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (iByte == PFX_F0) begin
            state_next = ST_GOT_F0;
          end else if (iByte == PFX_E0) begin
            // A break prefix followed by E0 is treated as a fresh extended code
            state_next = ST_GOT_E0;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_GOT_E0F0: begin
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_cnt <= SKIP_W'(1)) begin
            state_next = ST_IDLE;
            skip_next  = '0;
          end else begin
            skip_next  = skip_cnt - SKIP_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          skip_next  = '0;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Event and level-change decode for the byte arriving this cycle.
  always_comb begin
    evt_fire = 1'b0;
    evt_make = 1'b0;
    evt_ext  = 1'b0;
    lvl_set  = '0;
    lvl_clr  = '0;
    if (iByteValid) begin
      case (state)
        ST_IDLE: begin
          if (is_prefix(iByte) || is_status(iByte)) begin
            evt_fire = 1'b0;
          end else if (is_overrun(iByte)) begin
            lvl_clr = '1;
          end else begin
            evt_fire = 1'b1;
            evt_make = 1'b1;
            lvl_set  = key_mask(iByte);
          end
        end
        ST_GOT_E0: begin
          if ((iByte != PFX_F0) && (iByte != PFX_E0)) begin
            evt_fire = 1'b1;
            evt_make = 1'b1;
            evt_ext  = 1'b1;
          end else begin
            evt_fire = 1'b0;
          end
        end
        ST_GOT_F0: begin
          if ((iByte != PFX_F0) && (iByte != PFX_E0)) begin
            evt_fire = 1'b1;
            lvl_clr  = key_mask(iByte);
          end else begin
            evt_fire = 1'b0;
          end
        end
        ST_GOT_E0F0: begin
          if (!is_prefix(iByte)) begin
            evt_fire = 1'b1;
            evt_ext  = 1'b1;
          end else begin
            evt_fire = 1'b0;
          end
        end
        default: begin
          evt_fire = 1'b0;
        end
      endcase
    end else begin
      evt_fire = 1'b0;
    end
  end

  // Registered outputs: levels, event strobe and held event descriptor.
  always_ff @(posedge clk) begin
    if (iReset) begin
      levels    <= '0;
      key_event <= 1'b0;
      key_code  <= 8'h00;
      key_make  <= 1'b0;
      key_ext   <= 1'b0;
    end else begin
      levels    <= (levels & ~lvl_clr) | lvl_set;
      key_event <= evt_fire;
      if (evt_fire) begin
        key_code <= iByte;
        key_make <= evt_make;
        key_ext  <= evt_ext;
      end else begin
        key_code <= key_code;
        key_make <= key_make;
        key_ext  <= key_ext;
      end
    end
  end

  assign oOnePressed   = levels[LVL_ONE];
  assign oTwoPressed   = levels[LVL_TWO];
  assign oSpacePressed = levels[LVL_SPACE];
  assign oEnterPressed = levels[LVL_ENTER];
  assign oEscPressed   = levels[LVL_ESC];
  assign oKeyEvent     = key_event;
  assign oKeyCode      = key_code;
  assign oMake         = key_make;
  assign oExtended     = key_ext;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random
// byte streams compared against a byte-level behavioural model.
module tb_ps2_key_decoder;

  localparam int T     = 24;
  localparam int SKIPN = 7;

  logic       clk = 1'b0;
  logic       iReset;
  logic [7:0] iByte;
  logic       iByteValid;
  logic       oOnePressed, oTwoPressed, oSpacePressed, oEnterPressed, oEscPressed;
  logic       oKeyEvent;
  logic [7:0] oKeyCode;
  logic       oMake, oExtended;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .PAUSE_SKIP(SKIPN)) dut (
    .clk(clk), .iReset(iReset), .iByte(iByte), .iByteValid(iByteValid),
    .oOnePressed(oOnePressed), .oTwoPressed(oTwoPressed),
    .oSpacePressed(oSpacePressed), .oEnterPressed(oEnterPressed),
    .oEscPressed(oEscPressed), .oKeyEvent(oKeyEvent), .oKeyCode(oKeyCode),
    .oMake(oMake), .oExtended(oExtended)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending-prefix flags, remaining Pause bytes, idle gap
  bit         p_ext, p_brk;
  int         p_skip;
  int         gap_cnt;
  logic [4:0] m_lvl;   // {esc, enter, space, two, one}
  logic       m_evt;
  logic [7:0] m_code;
  logic       m_make, m_ext;

  function automatic int key_bit(input logic [7:0] b);
    if (b == 8'h16) return 0;
    if (b == 8'h1E) return 1;
    if (b == 8'h29) return 2;
    if (b == 8'h5A) return 3;
    if (b == 8'h76) return 4;
    return -1;
  endfunction

  function automatic logic [15:0] obs();
    return {oKeyEvent, oKeyCode, oMake, oExtended,
            oEscPressed, oEnterPressed, oSpacePressed, oTwoPressed, oOnePressed};
  endfunction

  function automatic logic [15:0] expv();
    return {m_evt, m_code, m_make, m_ext, m_lvl};
  endfunction

  task automatic model_reset();
    p_ext = 0; p_brk = 0; p_skip = 0; gap_cnt = 0;
    m_lvl = 5'b0; m_evt = 1'b0; m_code = 8'h00; m_make = 1'b0; m_ext = 1'b0;
  endtask

  task automatic emit(input logic [7:0] b, input logic mk, input logic ex);
    int k;
    m_evt = 1'b1; m_code = b; m_make = mk; m_ext = ex;
    k = key_bit(b);
    if (!ex && k >= 0) m_lvl[k] = mk;
  endtask

  // Interpret one received byte the way the keyboard protocol defines it.
  task automatic model_byte(input logic [7:0] b);
    m_evt = 1'b0;
    if ((p_ext || p_brk || p_skip > 0) && gap_cnt >= T) begin
      p_ext = 0; p_brk = 0; p_skip = 0;
    end
    if (p_skip > 0) begin
      p_skip--;
    end else if (!p_ext && !p_brk) begin
      if (b == 8'hE0) p_ext = 1;
      else if (b == 8'hF0) p_brk = 1;
      else if (b == 8'hE1) p_skip = SKIPN;
      else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE}) begin end
      else if (b == 8'h00 || b == 8'hFF) m_lvl = 5'b0;
      else emit(b, 1'b1, 1'b0);
    end else if (p_ext && !p_brk) begin
      if (b == 8'hF0) p_brk = 1;
      else if (b == 8'hE0) begin end
      else begin emit(b, 1'b1, 1'b1); p_ext = 0; end
    end else if (!p_ext && p_brk) begin
      if (b == 8'hF0) begin end
      else if (b == 8'hE0) begin p_ext = 1; p_brk = 0; end
      else begin emit(b, 1'b0, 1'b0); p_brk = 0; end
    end else begin
      if (!(b inside {8'hE0, 8'hF0, 8'hE1})) emit(b, 1'b0, 1'b1);
      p_ext = 0; p_brk = 0;
    end
    gap_cnt = 0;
  endtask

  // Present one byte for one cycle; outputs are sampled 1 time unit later.
  task automatic send(input logic [7:0] b);
    iByte = b; iByteValid = 1'b1;
    @(posedge clk); #1;
    iByteValid = 1'b0;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    gap_cnt += n;
    m_evt = 1'b0;
  endtask

  task automatic do_reset();
    iReset = 1'b1; iByteValid = 1'b0; iByte = 8'h00;
    repeat (2) @(posedge clk); #1;
    iReset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== 16'h0000) begin
      failures++; $display("FAIL reset_state got=%h need=0000", obs());
    end
    // Reset mid-sequence drops the pending break prefix
    send(8'hF0);
    iReset = 1'b1; @(posedge clk); #1; iReset = 1'b0; model_reset();
    send(8'h16);
    checks++;
    if (!(oKeyEvent === 1'b1 && oMake === 1'b1 && oOnePressed === 1'b1)) begin
      failures++; $display("FAIL reset_mid_seq got=%h need=make of 16 with one held", obs());
    end
  endtask

  task automatic test_make_break();
    logic [7:0] seq[$] = '{8'h16, 8'hF0, 8'h16};
    int gaps[$] = '{3, 0, 2};
    do_reset();
    foreach (seq[i]) begin
      send(seq[i]);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL make_break[%0d] got=%h need=%h", i, obs(), expv());
      end
      if (i == 0) begin
        checks++;
        if (!(oOnePressed === 1'b1 && oKeyEvent === 1'b1 && oKeyCode === 8'h16)) begin
          failures++; $display("FAIL make_one_level got=%h need one=1 evt=1 code=16", obs());
        end
      end
      idle(gaps[i]);
    end
    checks++;
    if (!(oOnePressed === 1'b0 && oMake === 1'b0 && oExtended === 1'b0 && oKeyEvent === 1'b0)) begin
      failures++; $display("FAIL break_one_level got=%h need one=0 make=0 ext=0 evt=0", obs());
    end
  endtask

  task automatic test_two_keys();
    logic [7:0] seq[$] = '{8'h1E, 8'h16, 8'hF0, 8'h1E};
    do_reset();
    foreach (seq[i]) begin
      send(seq[i]);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL two_keys[%0d] got=%h need=%h", i, obs(), expv());
      end
      if (i == 1) begin
        checks++;
        if (!(oOnePressed === 1'b1 && oTwoPressed === 1'b1)) begin
          failures++; $display("FAIL both_held got one=%b two=%b need 1 1", oOnePressed, oTwoPressed);
        end
      end
      idle(1);
    end
    checks++;
    if (!(oOnePressed === 1'b1 && oTwoPressed === 1'b0)) begin
      failures++; $display("FAIL two_released got one=%b two=%b need 1 0", oOnePressed, oTwoPressed);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq[$] = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'hE0, 8'h76};
    int nevt = 0;
    do_reset();
    foreach (seq[i]) begin
      send(seq[i]);
      checks++;
      if (obs() !== expv() || oEnterPressed !== 1'b0 || oEscPressed !== 1'b0) begin
        failures++; $display("FAIL extended[%0d] got=%h need=%h", i, obs(), expv());
      end
      if (oKeyEvent === 1'b1) nevt++;
      idle(1);
    end
    checks++;
    if (nevt != 3) begin
      failures++; $display("FAIL extended_event_count got=%0d need=3", nevt);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq[$] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    int nevt = 0;
    do_reset();
    foreach (seq[i]) begin
      send(seq[i]);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL pause[%0d] got=%h need=%h", i, obs(), expv());
      end
      if (i < 8 && oKeyEvent === 1'b1) nevt++;
    end
    checks++;
    if (nevt != 0 || oSpacePressed !== 1'b1 || oKeyEvent !== 1'b1 || oKeyCode !== 8'h29) begin
      failures++; $display("FAIL pause_then_space got evts=%0d obs=%h need 0 events then space make", nevt, obs());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h16);                 // hold '1' so a stale break would be visible
    send(8'hF0); idle(T - 1); send(8'h16);
    checks++;
    if (oMake !== 1'b0 || oOnePressed !== 1'b0 || obs() !== expv()) begin
      failures++; $display("FAIL timeout_boundary got=%h need=%h", obs(), expv());
    end
    send(8'hF0); idle(T); send(8'h76);
    checks++;
    if (!(oKeyEvent === 1'b1 && oMake === 1'b1 && oEscPressed === 1'b1 && oExtended === 1'b0)) begin
      failures++; $display("FAIL timeout_f0 got=%h need esc make", obs());
    end
    send(8'hE1); idle(T); send(8'h29);
    checks++;
    if (obs() !== expv() || oSpacePressed !== 1'b1) begin
      failures++; $display("FAIL timeout_skip got=%h need=%h", obs(), expv());
    end
    send(8'hE0); send(8'hF0); idle(T + 3); send(8'h5A);
    checks++;
    if (obs() !== expv() || oEnterPressed !== 1'b1 || oExtended !== 1'b0) begin
      failures++; $display("FAIL timeout_e0f0 got=%h need=%h", obs(), expv());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send(8'h16); send(8'h29); idle(2);
    send(8'hFF);
    checks++;
    if (!(oKeyEvent === 1'b0 && obs() === expv() && m_lvl === 5'b0)) begin
      failures++; $display("FAIL overrun_ff got=%h need=%h", obs(), expv());
    end
    send(8'hAA); send(8'h1E); send(8'h00);
    checks++;
    if (obs() !== expv() || oTwoPressed !== 1'b0) begin
      failures++; $display("FAIL overrun_00 got=%h need=%h", obs(), expv());
    end
    // Reset wins over a simultaneous byte
    send(8'h16);
    iReset = 1'b1; iByte = 8'h16; iByteValid = 1'b1;
    @(posedge clk); #1;
    iReset = 1'b0; iByteValid = 1'b0; model_reset();
    checks++;
    if (obs() !== 16'h0000) begin
      failures++; $display("FAIL reset_vs_byte got=%h need=0000", obs());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[$] = '{8'h16, 8'h16, 8'h16, 8'hF0, 8'h1E, 8'h1E, 8'hF0, 8'hF0, 8'h16, 8'h5A, 8'h76};
    do_reset();
    foreach (seq[i]) begin
      send(seq[i]);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL back_to_back[%0d] got=%h need=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[$] = '{8'h16, 8'h1E, 8'h29, 8'h5A, 8'h76, 8'hE0, 8'hF0, 8'hF0,
                            8'hE1, 8'hAA, 8'hFA, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h16};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r, gap;
      send(pool[$urandom_range(0, pool.size() - 1)]);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random[%0d] got=%h need=%h", n, obs(), expv());
      end
      r = $urandom_range(0, 39);
      if (r < 20) gap = 0;
      else if (r < 37) gap = $urandom_range(1, 4);
      else if (r == 37) gap = T - 1;
      else gap = T + $urandom_range(0, 2);
      if (gap > 0) begin
        idle(1);
        checks++;
        if (oKeyEvent !== 1'b0) begin
          failures++; $display("FAIL random_strobe[%0d] got=%b need=0", n, oKeyEvent);
        end
        idle(gap - 1);
      end
    end
  endtask

  initial begin
    iReset = 1'b1; iByte = 8'h00; iByteValid = 1'b0;
    model_reset();
    test_reset();
    test_make_break();
    test_two_keys();
    test_extended();
    test_pause();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
